// File: rtl/demux3_buf.sv
// ============================================================================
// Module   : demux3_buf
// Brief    : 1-to-3 demultiplexer with a small valid/ready FIFO per output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux3_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2   // 2 or 4 only
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2
);

  localparam int                 c_ptr_w = (DEPTH > 2) ? 2 : 1;
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);
  localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

  logic [2:0]       w_sel_oh;
  logic [2:0]       w_full;
  logic [2:0]       w_valid;
  logic [WIDTH-1:0] w_y   [3];
  logic [7:0]       w_cnt [3];

  // s=11 aliases onto channel 2
  always_comb begin
    w_sel_oh = 3'b000;
    case (s)
      2'b00:   w_sel_oh = 3'b001;
      2'b01:   w_sel_oh = 3'b010;
      default: w_sel_oh = 3'b100;
    endcase
  end

  // Ready looks only at registered fullness, so a pop never frees a slot for
  // the same cycle.
  assign in_ready = |(w_sel_oh & ~w_full);

  for (genvar k = 0; k < 3; k++) begin : g_ch
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr;
    logic [c_ptr_w-1:0] r_rd;
    logic [c_ptr_w:0]   r_occ;
    logic [7:0]         r_cnt;
    logic               w_push;
    logic               w_pop;

    assign w_full[k]  = (r_occ == c_full);
    assign w_valid[k] = (r_occ != '0);
    assign w_push     = in_valid & w_sel_oh[k] & ~w_full[k];
    assign w_pop      = w_valid[k] & out_ready[k];
    assign w_y[k]     = w_valid[k] ? r_mem[r_rd] : '0;
    assign w_cnt[k]   = r_cnt;

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr] <= d;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_occ <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) begin
          r_wr  <= (r_wr == c_last) ? '0 : r_wr + 1'b1;
          r_cnt <= r_cnt + 8'd1;
        end
        if (w_pop) begin
          r_rd <= (r_rd == c_last) ? '0 : r_rd + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign y0        = w_y[0];
  assign y1        = w_y[1];
  assign y2        = w_y[2];
  assign out_valid = w_valid;
  assign cnt0      = w_cnt[0];
  assign cnt1      = w_cnt[1];
  assign cnt2      = w_cnt[2];

endmodule

`default_nettype wire

// File: doc/demux3_buf.md
DEMUX3_BUF -- requirements
Module: demux3_buf

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output channel FIFO; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 d  input  WIDTH  data word to be routed.
REQ-006 s  input  2  channel select.
REQ-007 in_valid  input  1  d/s valid this cycle.
REQ-008 in_ready  output  1  block accepts d this cycle.
REQ-009 y0, y1, y2  output  WIDTH each  head word of channel 0/1/2 FIFO.
REQ-010 out_valid  output  3  bit k set: yk holds a valid word.
REQ-011 out_ready  input  3  bit k set: consumer k takes yk this cycle.
REQ-012 cnt0, cnt1, cnt2  output  8 each  words accepted into channel 0/1/2 since reset.

Function
REQ-013 Select decode SHALL be: s=00 -> ch0, s=01 -> ch1, s=10 -> ch2, s=11 -> ch2.
REQ-014 in_ready SHALL be 1 iff the FIFO of the decoded channel is not full; it SHALL depend only on s and registered state, never on out_ready.
REQ-015 Push: at a rising edge with in_valid=1 and in_ready=1, d SHALL be written to the tail of the decoded channel FIFO; only that FIFO changes.
REQ-016 in_valid=1 with in_ready=0: no write, no counter change; the word is not dropped and the source holds d/s.
REQ-017 Latency: a word pushed into an empty FIFO at edge N SHALL appear on yk with out_valid[k]=1 immediately after edge N (one cycle).
REQ-018 Pop: at a rising edge with out_valid[k]=1 and out_ready[k]=1, the head of FIFO k SHALL be removed; next entry, if any, appears after that edge.
REQ-019 out_ready[k]=1 with out_valid[k]=0: no effect.
REQ-020 Simultaneous push and pop on the same channel: both take effect; occupancy unchanged; FIFO order preserved.
REQ-021 Full FIFO with pop in the same cycle: in_ready stays 0 that cycle (no same-cycle pass-through); push is accepted no earlier than the next cycle.
REQ-022 All three channels SHALL pop independently in the same cycle.
REQ-023 yk SHALL be all zeros whenever out_valid[k]=0.
REQ-024 out_valid[k] SHALL equal (occupancy of FIFO k != 0).
REQ-025 cntk SHALL increment by 1 on each accepted push to channel k, wrapping 255 -> 0; pops do not affect it.
REQ-026 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH with no overflow or underflow.

Reset
REQ-027 While reset_n=0, regardless of clk: all FIFOs empty, out_valid=000, y0=y1=y2=0, cnt0=cnt1=cnt2=0.
REQ-028 in_ready during reset SHALL be 1 (all FIFOs empty).
REQ-029 Reset asserted mid-operation SHALL discard all stored words immediately; no partial push or pop completes.
REQ-030 After reset_n rises, the first push SHALL be accepted at the first rising edge with in_valid=1.

Verification
REQ-031 Routing: after reset, push d=8'hA1 with s=00, 8'hB2 with s=01, 8'hC3 with s=10, 8'hD4 with s=11, out_ready=000 -> y0=A1, y1=B2, y2=C3, out_valid=111, cnt0=1, cnt1=1, cnt2=2, ch2 holds C3 then D4.
REQ-032 Full/backpressure (DEPTH=2): push 8'h11, 8'h22 to ch1 with out_ready=000 -> in_ready=0 for s=01, in_ready=1 for s=00; a third in_valid held 3 cycles leaves cnt1=2 and y1=11.
REQ-033 Full with pop: ch1 full (11,22), out_ready[1]=1 with in_valid=1, d=33, s=01 -> edge 1: y1=22, no push; edge 2: push 33; y1 sequence 11, 22, 33.
REQ-034 Simultaneous push/pop: ch0 holds 8'h55, push 8'h66 and pop in the same cycle -> y0=66, out_valid[0]=1, cnt0 incremented by 1.
REQ-035 Counter wrap: 256 accepted pushes to ch2 with out_ready[2]=1 -> cnt2=0, cnt0=cnt1=0, out_valid[2]=0 after the final pop.
REQ-036 Async reset: with all FIFOs non-empty, drop reset_n between clock edges -> out_valid=000, y0=y1=y2=0, cnt0=cnt1=cnt2=0 without a clock edge; in_ready=1.
